// File: rtl/fpadd_pkg.sv
// Shared types and constants for the FP adder batch sequencer.
package fpadd_pkg;

  localparam int FP_W         = 32;
  localparam int DEF_ADDR_W   = 3;
  localparam int DEF_NUM_OPS  = 8;
  localparam int DEF_MEM_LAT  = 1;
  localparam int DEF_PIPE_LAT = 4;

  // IEEE-754 single-precision 1.0 and 2.0.
  localparam logic [FP_W-1:0] FP_ONE = 32'h3F80_0000;
  localparam logic [FP_W-1:0] FP_TWO = 32'h4000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fpadd_seq_ctrl_if.sv
// Bus between the batch sequencer, the operand memory and the FP adder.
// master: the sequencer. slave: memory/adder/debouncer side.
interface fpadd_seq_ctrl_if
  import fpadd_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              start;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [FP_W-1:0]   mem_a;
  logic [FP_W-1:0]   mem_b;
  logic [FP_W-1:0]   add_a;
  logic [FP_W-1:0]   add_b;
  logic              add_vld;
  logic [FP_W-1:0]   add_res;
  logic              res_vld;
  logic [ADDR_W-1:0] res_idx;
  logic [FP_W-1:0]   last_res;
  logic              busy;
  logic              done;

  modport master (
    input  start, mem_a, mem_b, add_res,
    output mem_rd_en, mem_addr, add_a, add_b, add_vld,
           res_vld, res_idx, last_res, busy, done
  );

  modport slave (
    output start, mem_a, mem_b, add_res,
    input  mem_rd_en, mem_addr, add_a, add_b, add_vld,
           res_vld, res_idx, last_res, busy, done
  );
endinterface

// File: rtl/fpadd_valid_pipe.sv
// Valid/index shift register that follows each issued read through the
// memory and adder latencies. Stage i (0-based) holds the read issued i+1
// cycles ago. tap_vld marks operands at the adder input, load_vld marks the
// cycle before (when operand registers must capture memory data), out_vld /
// out_idx mark a result leaving the adder.
module fpadd_valid_pipe #(
  parameter int DEPTH = 5,
  parameter int TAP   = 1,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [IDX_W-1:0] in_idx,
  output logic             load_vld,
  output logic             tap_vld,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx
);

  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0][IDX_W-1:0] idx_q;

  // Shift valid and index one stage per clock.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: every stage is reset, not just the first: a reset must discard
    // operations already in flight, so no stale valid may shift out later.
    if (!rst) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let each stage read the previous
      // stage's old value, so this loop describes a shift, not a copy-through.
      vld_q[0] <= in_vld;
      idx_q[0] <= in_idx;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  if (TAP == 1) begin : g_load_in
    assign load_vld = in_vld;
  end else begin : g_load_stage
    assign load_vld = vld_q[TAP-2];
  end

  assign tap_vld = vld_q[TAP-1];
  assign out_vld = vld_q[DEPTH-1];
  assign out_idx = idx_q[DEPTH-1];

endmodule

// File: rtl/fpadd_seq_ctrl.sv
// Batch sequencer for the pipelined FP adder. A start pulse reads NUM_OPS
// operand pairs (one per cycle) and streams them into the adder; results
// retire with their index and the latest one is held on last_res.
// Operand data is sampled MEM_LAT clock edges after the read strobe is driven,
// so MEM_LAT=1 means data is presented in the same cycle as mem_rd_en.
// Build option FPADD_STEP_EN: each start issues a single operation at a
// persistent step index that advances (wrapping at NUM_OPS) per retired result.
module fpadd_seq_ctrl
  import fpadd_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_OPS  = DEF_NUM_OPS,
  parameter int MEM_LAT  = DEF_MEM_LAT,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input logic              clk,
  input logic              rst,
  fpadd_seq_ctrl_if.master bus
);

  localparam int                DEPTH    = MEM_LAT + PIPE_LAT;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_OPS - 1);

  state_t            state;
  logic [ADDR_W-1:0] iss_cnt;
  logic              rd_en_q;
  logic              busy_q;
  logic              done_q;
  logic [FP_W-1:0]   add_a_q;
  logic [FP_W-1:0]   add_b_q;
  logic [FP_W-1:0]   last_q;

  logic              load_ops;
  logic              add_vld;
  logic              res_vld;
  logic [ADDR_W-1:0] res_idx;

  // Index of the first read, the last read, and the result that ends the run.
  logic [ADDR_W-1:0] first_idx;
  logic [ADDR_W-1:0] issue_last;
  logic [ADDR_W-1:0] retire_last;
  logic              retire_done;

  assign retire_done = (state == ST_DRAIN) && res_vld && (res_idx == retire_last);

`ifdef FPADD_STEP_EN
  logic [ADDR_W-1:0] step_idx;

  assign first_idx   = step_idx;
  assign issue_last  = step_idx;
  assign retire_last = step_idx;

  // Advance the persistent step index once its result has retired.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_idx <= '0;
    end else if (retire_done) begin
      step_idx <= (step_idx == LAST_IDX) ? '0 : step_idx + 1'b1;
    end
  end
`else
  assign first_idx   = '0;
  assign issue_last  = LAST_IDX;
  assign retire_last = LAST_IDX;
`endif

  // Control FSM: state, issue counter and registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      iss_cnt <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state   <= ST_ISSUE;
            iss_cnt <= first_idx;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          // Full batch with NUM_OPS = 2**ADDR_W wraps to 0 here; no read follows.
          iss_cnt <= iss_cnt + 1'b1;
          if (iss_cnt == issue_last) begin
            state   <= ST_DRAIN;
            rd_en_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (retire_done) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  fpadd_valid_pipe #(
    .DEPTH (DEPTH),
    .TAP   (MEM_LAT),
    .IDX_W (ADDR_W)
  ) u_valid_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rd_en_q),
    .in_idx   (iss_cnt),
    .load_vld (load_ops),
    .tap_vld  (add_vld),
    .out_vld  (res_vld),
    .out_idx  (res_idx)
  );

  // Capture operands only for real operations; otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_a_q <= '0;
      add_b_q <= '0;
    end else if (load_ops) begin
      add_a_q <= bus.mem_a;
      add_b_q <= bus.mem_b;
    end
  end

  // Remember the most recent retired result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= '0;
    end else if (res_vld) begin
      last_q <= bus.add_res;
    end
  end

  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_addr  = iss_cnt;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_vld   = add_vld;
  assign bus.res_vld   = res_vld;
  assign bus.res_idx   = res_idx;
  // Retiring result is visible on last_res in its own cycle, then held.
  assign bus.last_res  = res_vld ? bus.add_res : last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_fpadd_seq_ctrl.sv
// Bench for fpadd_seq_ctrl: models the operand memory and a PIPE_LAT-stage
// adder, and checks timing and results against expectations derived from
// cycle formulas and integer arithmetic on the stored operands.
`timescale 1ns/1ps
module tb_fpadd_seq_ctrl;
  import fpadd_pkg::*;

  localparam int ADDR_W   = 3;
  localparam int NUM_OPS  = 8;
  localparam int MEM_LAT  = 1;
  localparam int PIPE_LAT = 4;
  localparam int RES_LAT  = 1 + MEM_LAT + PIPE_LAT;
  localparam int MEM_SZ   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  int unsigned     val_a [MEM_SZ];
  int unsigned     val_b [MEM_SZ];
  logic [FP_W-1:0] mem_a_arr [MEM_SZ];
  logic [FP_W-1:0] mem_b_arr [MEM_SZ];
  logic [FP_W-1:0] add_pipe [PIPE_LAT];

  fpadd_seq_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  fpadd_seq_ctrl #(
    .ADDR_W   (ADDR_W),
    .NUM_OPS  (NUM_OPS),
    .MEM_LAT  (MEM_LAT),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Integer-valued single-precision helpers (operands kept below 2**24).
  function automatic logic [31:0] int_to_fp(input int unsigned n);
    int          p;
    logic [31:0] m;
    if (n == 0) return 32'h0;
    p = 31;
    while (n[p] == 1'b0) p--;
    m = n << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int unsigned fp_to_int(input logic [31:0] f);
    int          e;
    logic [31:0] m;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 127;
    m = {8'h0, 1'b1, f[22:0]};
    return m >> (23 - e);
  endfunction

  function automatic logic [31:0] exp_sum(input int k);
    return int_to_fp(val_a[k] + val_b[k]);
  endfunction

  // Operand memory: data for mem_addr is presented in the read cycle.
  assign bus.mem_a   = mem_a_arr[bus.mem_addr];
  assign bus.mem_b   = mem_b_arr[bus.mem_addr];
  assign bus.add_res = add_pipe[PIPE_LAT-1];

  // Adder: PIPE_LAT-cycle pipeline, computes every cycle.
  always @(posedge clk) begin
    add_pipe[0] <= int_to_fp(fp_to_int(bus.add_a) + fp_to_int(bus.add_b));
    for (int i = 1; i < PIPE_LAT; i++) add_pipe[i] <= add_pipe[i-1];
  end

  task automatic fill_mem();
    for (int k = 0; k < MEM_SZ; k++) begin
      val_a[k]     = $urandom_range(3, 1000000);
      val_b[k]     = $urandom_range(3, 1000000);
      mem_a_arr[k] = int_to_fp(val_a[k]);
      mem_b_arr[k] = int_to_fp(val_b[k]);
    end
  endtask

  // Start is sampled at the returning posedge (cycle 0); next negedge is cycle 1.
  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [106:0] outs;
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    outs = {bus.mem_rd_en, bus.mem_addr, bus.add_a, bus.add_b, bus.add_vld,
            bus.res_vld, bus.res_idx, bus.last_res, bus.busy, bus.done};
    tests_run++;
    if (outs !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %0h expected 0", outs);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if ({bus.busy, bus.done, bus.mem_rd_en, bus.res_vld} !== 4'b0) begin
        tests_failed++;
        $display("FAIL idle_after_reset: busy/done/rd/res got %b expected 0000",
                 {bus.busy, bus.done, bus.mem_rd_en, bus.res_vld});
      end
    end
  endtask

`ifdef FPADD_STEP_EN
  task automatic test_step(input int n_steps);
    int reads, seen, idx;
    for (int s = 0; s < n_steps; s++) begin
      idx = s % NUM_OPS;
      pulse_start();
      reads = 0;
      seen  = 0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
        @(negedge clk);
        if (bus.mem_rd_en) begin
          reads++;
          tests_run++;
          if (cyc != 1 || bus.mem_addr !== ADDR_W'(idx)) begin
            tests_failed++;
            $display("FAIL step_read: cycle %0d addr %0d expected cycle 1 addr %0d",
                     cyc, bus.mem_addr, idx);
          end
        end
        if (bus.res_vld) begin
          seen++;
          tests_run++;
          if (cyc != RES_LAT || bus.res_idx !== ADDR_W'(idx) || bus.last_res !== exp_sum(idx)) begin
            tests_failed++;
            $display("FAIL step_result: cycle %0d idx %0d val %h expected cycle %0d idx %0d val %h",
                     cyc, bus.res_idx, bus.last_res, RES_LAT, idx, exp_sum(idx));
          end
        end
        if (cyc == 1 || cyc == RES_LAT + 1) begin
          tests_run++;
          if ({bus.busy, bus.done} !== ((cyc == 1) ? 2'b10 : 2'b01)) begin
            tests_failed++;
            $display("FAIL step_busy_done: cycle %0d got %b expected %b",
                     cyc, {bus.busy, bus.done}, (cyc == 1) ? 2'b10 : 2'b01);
          end
        end
      end
      tests_run++;
      if (reads != 1 || seen != 1) begin
        tests_failed++;
        $display("FAIL step_counts: reads %0d results %0d expected 1 1", reads, seen);
      end
    end
  endtask
`else
  // Full batch with per-cycle timing; mem[0] = 1.0 + 2.0; covers address wrap.
  task automatic test_batch();
    int  k;
    logic exp_bit;
    fill_mem();
    val_a[0] = 1;  mem_a_arr[0] = FP_ONE;
    val_b[0] = 2;  mem_b_arr[0] = FP_TWO;
    pulse_start();
    for (int cyc = 1; cyc <= RES_LAT + NUM_OPS + 2; cyc++) begin
      @(negedge clk);
      exp_bit = (cyc <= NUM_OPS);
      tests_run++;
      if (bus.mem_rd_en !== exp_bit) begin
        tests_failed++;
        $display("FAIL mem_rd_en c%0d: got %b expected %b", cyc, bus.mem_rd_en, exp_bit);
      end
      if (exp_bit || cyc == NUM_OPS + 1) begin
        tests_run++;
        if (bus.mem_addr !== ADDR_W'((cyc - 1) % MEM_SZ)) begin
          tests_failed++;
          $display("FAIL mem_addr c%0d: got %0d expected %0d", cyc, bus.mem_addr, (cyc - 1) % MEM_SZ);
        end
      end
      k = cyc - 1 - MEM_LAT;
      exp_bit = (k >= 0 && k < NUM_OPS);
      tests_run++;
      if (bus.add_vld !== exp_bit) begin
        tests_failed++;
        $display("FAIL add_vld c%0d: got %b expected %b", cyc, bus.add_vld, exp_bit);
      end
      if (k >= 0) begin
        if (k >= NUM_OPS) k = NUM_OPS - 1;
        tests_run++;
        if (bus.add_a !== mem_a_arr[k] || bus.add_b !== mem_b_arr[k]) begin
          tests_failed++;
          $display("FAIL add_operands c%0d: got %h/%h expected %h/%h",
                   cyc, bus.add_a, bus.add_b, mem_a_arr[k], mem_b_arr[k]);
        end
      end
      k = cyc - RES_LAT;
      exp_bit = (k >= 0 && k < NUM_OPS);
      tests_run++;
      if (bus.res_vld !== exp_bit) begin
        tests_failed++;
        $display("FAIL res_vld c%0d: got %b expected %b", cyc, bus.res_vld, exp_bit);
      end
      if (exp_bit) begin
        tests_run++;
        if (bus.res_idx !== ADDR_W'(k)) begin
          tests_failed++;
          $display("FAIL res_idx c%0d: got %0d expected %0d", cyc, bus.res_idx, k);
        end
      end
      if (k >= 0) begin
        if (k >= NUM_OPS) k = NUM_OPS - 1;
        tests_run++;
        if (bus.last_res !== exp_sum(k)) begin
          tests_failed++;
          $display("FAIL last_res c%0d: got %h expected %h", cyc, bus.last_res, exp_sum(k));
        end
      end
      if (cyc == RES_LAT) begin
        tests_run++;
        if (bus.last_res !== 32'h4040_0000) begin
          tests_failed++;
          $display("FAIL one_plus_two: got %h expected 40400000", bus.last_res);
        end
      end
      exp_bit = (cyc < RES_LAT + NUM_OPS);
      tests_run++;
      if ({bus.busy, bus.done} !== {exp_bit, !exp_bit}) begin
        tests_failed++;
        $display("FAIL busy_done c%0d: got %b expected %b", cyc, {bus.busy, bus.done}, {exp_bit, !exp_bit});
      end
    end
  endtask

  // Start pulses during ISSUE and DRAIN must not restart the batch.
  task automatic test_start_ignored();
    int reads, results;
    fill_mem();
    pulse_start();
    reads = 0;
    results = 0;
    for (int cyc = 1; cyc <= RES_LAT + NUM_OPS + 6; cyc++) begin
      @(negedge clk);
      if (bus.mem_rd_en) begin
        tests_run++;
        if (bus.mem_addr !== ADDR_W'(reads % MEM_SZ)) begin
          tests_failed++;
          $display("FAIL ignored_start_addr c%0d: got %0d expected %0d", cyc, bus.mem_addr, reads % MEM_SZ);
        end
        reads++;
      end
      if (bus.res_vld) begin
        tests_run++;
        if (results >= NUM_OPS || bus.res_idx !== ADDR_W'(results) ||
            bus.last_res !== exp_sum(results % NUM_OPS)) begin
          tests_failed++;
          $display("FAIL ignored_start_result c%0d: idx %0d val %h expected idx %0d",
                   cyc, bus.res_idx, bus.last_res, results);
        end
        results++;
      end
      bus.start = (cyc == 8 || cyc == 11);
    end
    bus.start = 1'b0;
    tests_run++;
    if (reads != NUM_OPS || results != NUM_OPS || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignored_start_totals: reads %0d results %0d done %b busy %b expected %0d %0d 1 0",
               reads, results, bus.done, bus.busy, NUM_OPS, NUM_OPS);
    end
  endtask

  // Reset mid-batch: outputs clear at once, nothing stale retires afterwards.
  task automatic test_reset_abort();
    int stale, first;
    logic [106:0] outs;
    fill_mem();
    pulse_start();
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    outs = {bus.mem_rd_en, bus.mem_addr, bus.add_a, bus.add_b, bus.add_vld,
            bus.res_vld, bus.res_idx, bus.last_res, bus.busy, bus.done};
    tests_run++;
    if (outs !== '0) begin
      tests_failed++;
      $display("FAIL abort_outputs: got %0h expected 0", outs);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.res_vld || bus.add_vld || bus.busy || bus.done) stale++;
    end
    tests_run++;
    if (stale != 0) begin
      tests_failed++;
      $display("FAIL abort_stale: got %0d active cycles expected 0", stale);
    end
    pulse_start();
    first = -1;
    for (int cyc = 1; cyc <= RES_LAT + NUM_OPS; cyc++) begin
      @(negedge clk);
      if (bus.res_vld && first < 0) begin
        first = cyc;
        tests_run++;
        if (bus.res_idx !== '0 || bus.last_res !== exp_sum(0)) begin
          tests_failed++;
          $display("FAIL abort_restart_first: idx %0d val %h expected 0 %h",
                   bus.res_idx, bus.last_res, exp_sum(0));
        end
      end
    end
    tests_run++;
    if (first != RES_LAT || bus.done !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_restart_timing: first at %0d done %b expected %0d 1", first, bus.done, RES_LAT);
    end
  endtask

  // Randomised batches started from DONE with random gaps, scoreboarded.
  task automatic test_back_to_back();
    logic [ADDR_W+FP_W-1:0] exp_q[$];
    logic [ADDR_W+FP_W-1:0] e;
    int done_cyc;
    for (int b = 0; b < 3; b++) begin
      fill_mem();
      exp_q.delete();
      for (int k = 0; k < NUM_OPS; k++) exp_q.push_back({ADDR_W'(k), exp_sum(k)});
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pulse_start();
      done_cyc = -1;
      for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
        @(negedge clk);
        if (bus.res_vld) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL b2b_extra_result: batch %0d idx %0d", b, bus.res_idx);
          end else begin
            e = exp_q.pop_front();
            if ({bus.res_idx, bus.last_res} !== e) begin
              tests_failed++;
              $display("FAIL b2b_result: batch %0d got %0d/%h expected %0d/%h",
                       b, bus.res_idx, bus.last_res, e[ADDR_W+FP_W-1:FP_W], e[FP_W-1:0]);
            end
          end
        end
        if (bus.done) done_cyc = cyc;
      end
      tests_run++;
      if (done_cyc != RES_LAT + NUM_OPS || exp_q.size() != 0) begin
        tests_failed++;
        $display("FAIL b2b_done: batch %0d done at %0d left %0d expected %0d 0",
                 b, done_cyc, exp_q.size(), RES_LAT + NUM_OPS);
      end
    end
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    rst = 1'b0;
    test_reset();
`ifdef FPADD_STEP_EN
    fill_mem();
    test_step(NUM_OPS + 1);
    test_reset();
    test_step(2);
`else
    test_batch();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
